// File: rtl/vga_multi_sprite_display_pkg.sv
// Shared definitions for the multi-sprite VGA colour generator.
// Contents: RGB565 colour constants, the per-sprite colour table,
// the per-axis bounce step used by every sprite, and an 11-bit
// signed square helper for the circle hit test.
package vga_multi_sprite_display_pkg;

  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] MAGENTA = 16'hF81F;

  // One axis of sprite state after a move: position, direction
  // (1 = increasing, i.e. right/down) and whether a wall was hit.
  typedef struct packed {
    logic [10:0] pos;
    logic        inc;
    logic        hit;
  } axis_t;

  function automatic logic [15:0] spr_colour(input int idx);
    case (idx)
      0:       return RED;
      1:       return GREEN;
      2:       return BLACK;
      default: return MAGENTA;
    endcase
  endfunction

  // Move one axis by step, clamping to [lo, hi] and flipping direction
  // on contact so a sprite never overshoots a wall.
  function automatic axis_t step_axis(input logic [10:0] pos, input logic inc,
                                     input logic [10:0] lo, input logic [10:0] hi,
                                     input logic [10:0] step);
    axis_t r;
    r.pos = pos;
    r.inc = inc;
    r.hit = 1'b0;
    if (inc) begin
      if (pos + step >= hi) begin
        r.pos = hi;
        r.inc = 1'b0;
        r.hit = 1'b1;
      end else begin
        r.pos = pos + step;
      end
    end else begin
      if (pos <= lo + step) begin
        r.pos = lo;
        r.inc = 1'b1;
        r.hit = 1'b1;
      end else begin
        r.pos = pos - step;
      end
    end
    return r;
  endfunction

  // Square of an 11-bit signed distance as a 22-bit unsigned value.
  function automatic logic [21:0] sq11(input logic signed [10:0] v);
    logic [10:0] a;
    a = v[10] ? 11'(-v) : 11'(v);
    return 22'(a) * 22'(a);
  endfunction

endpackage

// File: rtl/vga_multi_sprite_display_if.sv
// Pixel interface between the VGA timing driver and the colour generator.
// master: timing side, drives pixel coordinates and the pause/shape
//         controls, receives the colour and the bounce pulses.
// slave : colour generator side.
interface vga_multi_sprite_display_if #(
  parameter int NUM_SPR = 2
);
  logic               pause;
  logic               shape_sel;
  logic [9:0]         pixel_xpos;
  logic [9:0]         pixel_ypos;
  logic [15:0]        pixel_data;
  logic [NUM_SPR-1:0] bounce;

  modport master (output pause, shape_sel, pixel_xpos, pixel_ypos,
                  input  pixel_data, bounce);
  modport slave  (input  pause, shape_sel, pixel_xpos, pixel_ypos,
                  output pixel_data, bounce);
endinterface

// File: rtl/vga_multi_sprite_display_sprite_mover.sv
// Position and direction state of one bouncing sprite.
// Ports: clk, rst (sync, active-high), tick (move strobe),
//        x/y (top-left corner of the sprite box), bounce (one-cycle
//        pulse on any wall contact, corner hits give a single pulse).
module vga_multi_sprite_display_sprite_mover
  import vga_multi_sprite_display_pkg::*;
#(
  parameter int X0     = 48,
  parameter int Y0     = 48,
  parameter bit RIGHT0 = 1'b1,
  parameter int X_MIN  = 40,
  parameter int X_MAX  = 560,
  parameter int Y_MIN  = 40,
  parameter int Y_MAX  = 400,
  parameter int STEP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        bounce
);
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        h_inc_q, h_inc_d, v_inc_q, v_inc_d;
  logic        bounce_q, bounce_d;
  axis_t       ax, ay;

  always_comb begin
    ax       = step_axis(x_q, h_inc_q, 11'(X_MIN), 11'(X_MAX), 11'(STEP));
    ay       = step_axis(y_q, v_inc_q, 11'(Y_MIN), 11'(Y_MAX), 11'(STEP));
    x_d      = x_q;
    y_d      = y_q;
    h_inc_d  = h_inc_q;
    v_inc_d  = v_inc_q;
    bounce_d = 1'b0;
    if (tick) begin
      x_d      = ax.pos;
      h_inc_d  = ax.inc;
      y_d      = ay.pos;
      v_inc_d  = ay.inc;
      bounce_d = ax.hit | ay.hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= 11'(X0);
      y_q      <= 11'(Y0);
      h_inc_q  <= RIGHT0;
      v_inc_q  <= 1'b1;
      bounce_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      h_inc_q  <= h_inc_d;
      v_inc_q  <= v_inc_d;
      bounce_q <= bounce_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign bounce = bounce_q;

endmodule

// File: rtl/vga_multi_sprite_display.sv
// Pixel-colour generator: blue border, NUM_SPR bouncing sprites
// (square or circle) on a white field, RGB565 output registered once.
// Ports: vga_clk (only clock), sys_rst (sync, active-high),
//        disp (slave side: pause, shape_sel, pixel_xpos/ypos in;
//        pixel_data, bounce out).
module vga_multi_sprite_display
  import vga_multi_sprite_display_pkg::*;
#(
  parameter int H_DISP   = 640,
  parameter int V_DISP   = 480,
  parameter int SIDE_W   = 40,
  parameter int SPR_SIZE = 40,
  parameter int NUM_SPR  = 2,
  parameter int STEP     = 1,
  parameter int DIV_MAX  = 250000
) (
  input  logic                         vga_clk,
  input  logic                         sys_rst,
  vga_multi_sprite_display_if.slave    disp
);
  localparam int          XMAX  = H_DISP - SIDE_W - SPR_SIZE;
  localparam int          YMAX  = V_DISP - SIDE_W - SPR_SIZE;
  localparam int          HALF  = SPR_SIZE / 2;
  localparam int          DIV_W = $clog2(DIV_MAX + 1);
  localparam logic [21:0] R2    = 22'(HALF * HALF);

  function automatic logic in_square(input logic [10:0] px, input logic [10:0] py,
                                     input logic [10:0] sx, input logic [10:0] sy);
    return (px >= sx) && (px < sx + 11'(SPR_SIZE)) &&
           (py >= sy) && (py < sy + 11'(SPR_SIZE));
  endfunction

  // Distances wrap in 11 bits and are reinterpreted as signed; screen
  // coordinates never span more than +/-1023 so the sign is exact.
  function automatic logic in_circle(input logic [10:0] px, input logic [10:0] py,
                                     input logic [10:0] sx, input logic [10:0] sy);
    logic signed [10:0] dx, dy;
    dx = signed'(px - (sx + 11'(HALF)));
    dy = signed'(py - (sy + 11'(HALF)));
    return (sq11(dx) + sq11(dy)) < R2;
  endfunction

  logic [DIV_W-1:0]   div_q, div_d;
  logic [15:0]        pix_q, pix_d;
  logic               tick;
  logic [10:0]        spr_x [NUM_SPR];
  logic [10:0]        spr_y [NUM_SPR];
  logic               spr_b [NUM_SPR];
  logic [NUM_SPR-1:0] bounce_w;
  logic [NUM_SPR-1:0] hit;
  logic [10:0]        px, py;
  logic               border;

  // Move-tick divider; pause freezes the count so no tick is lost or added.
  always_comb begin
    tick  = !disp.pause && (div_q == DIV_W'(DIV_MAX - 1));
    div_d = div_q;
    if (!disp.pause) div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
    vga_multi_sprite_display_sprite_mover #(
      .X0     (SIDE_W + 8 + g * (SPR_SIZE + 8)),
      .Y0     (SIDE_W + 8 + g * 16),
      .RIGHT0 (g % 2 == 0),
      .X_MIN  (SIDE_W),
      .X_MAX  (XMAX),
      .Y_MIN  (SIDE_W),
      .Y_MAX  (YMAX),
      .STEP   (STEP)
    ) u_mover (
      .clk    (vga_clk),
      .rst    (sys_rst),
      .tick   (tick),
      .x      (spr_x[g]),
      .y      (spr_y[g]),
      .bounce (spr_b[g])
    );
  end

  always_comb begin
    bounce_w = '0;
    for (int i = 0; i < NUM_SPR; i++) bounce_w[i] = spr_b[i];
  end
  assign disp.bounce = bounce_w;

  assign px     = {1'b0, disp.pixel_xpos};
  assign py     = {1'b0, disp.pixel_ypos};
  assign border = (px < 11'(SIDE_W)) || (px >= 11'(H_DISP - SIDE_W)) ||
                  (py < 11'(SIDE_W)) || (py >= 11'(V_DISP - SIDE_W));

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SPR; i++)
      hit[i] = disp.shape_sel ? in_circle(px, py, spr_x[i], spr_y[i])
                              : in_square(px, py, spr_x[i], spr_y[i]);
  end

  // Walk from the lowest-priority sprite up so the lowest index wins.
  always_comb begin
    pix_d = WHITE;
    for (int i = NUM_SPR - 1; i >= 0; i--)
      if (hit[i]) pix_d = spr_colour(i);
    if (border) pix_d = BLUE;
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      div_q <= '0;
      pix_q <= BLACK;
    end else begin
      div_q <= div_d;
      pix_q <= pix_d;
    end
  end

  assign disp.pixel_data = pix_q;

endmodule

// File: tb/tb_vga_multi_sprite_display.sv
module tb_vga_multi_sprite_display;
  localparam int H = 640, V = 480, SW = 40, SZ = 40, NS = 4, ST = 3, DIV = 4;
  localparam int XMAX = H - SW - SZ, YMAX = V - SW - SZ, HF = SZ / 2;
  localparam logic [15:0] C_BLUE = 16'h001F, C_WHITE = 16'hFFFF, C_BLACK = 16'h0000;
  localparam logic [15:0] C_RED = 16'hF800, C_GREEN = 16'h07E0, C_MAGENTA = 16'hF81F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_multi_sprite_display_if #(.NUM_SPR(NS)) vif ();

  vga_multi_sprite_display #(
    .H_DISP(H), .V_DISP(V), .SIDE_W(SW), .SPR_SIZE(SZ),
    .NUM_SPR(NS), .STEP(ST), .DIV_MAX(DIV)
  ) dut (
    .vga_clk (clk),
    .sys_rst (rst),
    .disp    (vif)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: sprite boxes, directions, divider, expected outputs.
  int            mx [NS];
  int            my [NS];
  bit            mh [NS];
  bit            mv [NS];
  int            mdiv;
  logic [15:0]   exp_pix;
  logic [NS-1:0] exp_b;

  function automatic logic [15:0] col_of(input int i);
    logic [15:0] t [4];
    t = '{C_RED, C_GREEN, C_BLACK, C_MAGENTA};
    return t[i];
  endfunction

  function automatic bit in_spr(input int i, input int px, input int py, input bit circ);
    int dx, dy;
    if (circ) begin
      dx = px - (mx[i] + HF);
      dy = py - (my[i] + HF);
      return dx * dx + dy * dy < HF * HF;
    end
    return px >= mx[i] && px < mx[i] + SZ && py >= my[i] && py < my[i] + SZ;
  endfunction

  function automatic logic [15:0] ref_colour(input int px, input int py, input bit circ);
    if (px < SW || px >= H - SW || py < SW || py >= V - SW) return C_BLUE;
    for (int i = 0; i < NS; i++) if (in_spr(i, px, py, circ)) return col_of(i);
    return C_WHITE;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      mx[i] = SW + 8 + i * (SZ + 8);
      my[i] = SW + 8 + i * 16;
      mh[i] = (i % 2 == 0);
      mv[i] = 1'b1;
    end
    mdiv    = 0;
    exp_pix = C_BLACK;
    exp_b   = '0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      exp_pix = ref_colour(int'(vif.pixel_xpos), int'(vif.pixel_ypos), vif.shape_sel);
      exp_b   = '0;
      if (!vif.pause) begin
        if (mdiv == DIV - 1) begin
          mdiv = 0;
          for (int i = 0; i < NS; i++) begin
            bit hx, hy;
            hx = 1'b0;
            hy = 1'b0;
            if (mh[i]) begin
              if (mx[i] + ST >= XMAX) begin mx[i] = XMAX; mh[i] = 1'b0; hx = 1'b1; end
              else mx[i] = mx[i] + ST;
            end else begin
              if (mx[i] <= SW + ST) begin mx[i] = SW; mh[i] = 1'b1; hx = 1'b1; end
              else mx[i] = mx[i] - ST;
            end
            if (mv[i]) begin
              if (my[i] + ST >= YMAX) begin my[i] = YMAX; mv[i] = 1'b0; hy = 1'b1; end
              else my[i] = my[i] + ST;
            end else begin
              if (my[i] <= SW + ST) begin my[i] = SW; mv[i] = 1'b1; hy = 1'b1; end
              else my[i] = my[i] - ST;
            end
            exp_b[i] = hx | hy;
          end
        end else begin
          mdiv = mdiv + 1;
        end
      end
    end
  end

  // Drive a probe pixel and wait for the registered colour.
  task automatic probe(input int px, input int py);
    vif.pixel_xpos = 10'(px);
    vif.pixel_ypos = 10'(py);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vif.pause = 1'b0;
    vif.shape_sel = 1'b0;
    probe(0, 0);
    probe(0, 0);
    total++;
    if (vif.pixel_data !== C_BLACK) begin bad++; $display("FAIL reset_pix got=%h want=%h", vif.pixel_data, C_BLACK); end
    total++;
    if (vif.bounce !== '0) begin bad++; $display("FAIL reset_bounce got=%b want=0", vif.bounce); end
    rst = 1'b0;
    probe(0, 0);
    total++;
    if (vif.pixel_data !== C_BLUE) begin bad++; $display("FAIL probe_0_0 got=%h want=%h", vif.pixel_data, C_BLUE); end
    probe(320, 20);
    total++;
    if (vif.pixel_data !== C_BLUE) begin bad++; $display("FAIL probe_320_20 got=%h want=%h", vif.pixel_data, C_BLUE); end
    probe(320, 240);
    total++;
    if (vif.pixel_data !== C_WHITE) begin bad++; $display("FAIL probe_320_240 got=%h want=%h", vif.pixel_data, C_WHITE); end
  endtask

  task automatic test_square(input int n);
    int offs [6];
    int k, px, py;
    offs = '{-1, 0, 1, SZ - 1, SZ, HF};
    vif.shape_sel = 1'b0;
    for (int c = 0; c < n; c++) begin
      k = $urandom_range(0, NS - 1);
      if ($urandom_range(0, 4) == 0) begin
        px = $urandom_range(0, H - 1);
        py = $urandom_range(0, V - 1);
      end else begin
        px = mx[k] + offs[$urandom_range(0, 5)];
        py = my[k] + offs[$urandom_range(0, 5)];
      end
      probe(px, py);
      total++;
      if (vif.pixel_data !== exp_pix) begin bad++; $display("FAIL square_pix (%0d,%0d) got=%h want=%h", px, py, vif.pixel_data, exp_pix); end
      total++;
      if (vif.bounce !== exp_b) begin bad++; $display("FAIL square_bounce got=%b want=%b", vif.bounce, exp_b); end
    end
  endtask

  task automatic test_circle(input int n);
    int offs [8];
    int k, px, py;
    offs = '{0, 3, HF - 1, HF, HF + 1, SZ - 4, SZ - 1, SZ};
    vif.shape_sel = 1'b1;
    probe(mx[0] + HF, my[0] + HF);
    total++;
    if (vif.pixel_data !== C_RED) begin bad++; $display("FAIL circle_centre got=%h want=%h", vif.pixel_data, C_RED); end
    probe(mx[0] + SZ - 1, my[0] + HF);
    total++;
    if (vif.pixel_data !== C_RED) begin bad++; $display("FAIL circle_right_edge got=%h want=%h", vif.pixel_data, C_RED); end
    probe(mx[0] + SZ, my[0] + HF);
    total++;
    if (vif.pixel_data === C_RED || vif.pixel_data !== exp_pix) begin bad++; $display("FAIL circle_outside got=%h want=%h", vif.pixel_data, exp_pix); end
    probe(mx[0], my[0]);
    total++;
    if (vif.pixel_data === C_RED || vif.pixel_data !== exp_pix) begin bad++; $display("FAIL circle_corner got=%h want=%h", vif.pixel_data, exp_pix); end
    for (int c = 0; c < n; c++) begin
      k = $urandom_range(0, NS - 1);
      px = mx[k] + offs[$urandom_range(0, 7)];
      py = my[k] + offs[$urandom_range(0, 7)];
      probe(px, py);
      total++;
      if (vif.pixel_data !== exp_pix) begin bad++; $display("FAIL circle_pix (%0d,%0d) got=%h want=%h", px, py, vif.pixel_data, exp_pix); end
      total++;
      if (vif.bounce !== exp_b) begin bad++; $display("FAIL circle_bounce got=%b want=%b", vif.bounce, exp_b); end
    end
  endtask

  task automatic test_bounce(input int n);
    int nd, nr, k;
    nd = 0;
    nr = 0;
    vif.shape_sel = 1'b0;
    for (int c = 0; c < n; c++) begin
      k = $urandom_range(0, NS - 1);
      probe(mx[k] + ($urandom_range(0, 1) ? SZ - 1 : SZ), my[k] + HF);
      nd += $countones(vif.bounce);
      nr += $countones(exp_b);
      total++;
      if (vif.bounce !== exp_b) begin bad++; $display("FAIL bounce_pulse cycle=%0d got=%b want=%b", c, vif.bounce, exp_b); end
      total++;
      if (vif.pixel_data !== exp_pix) begin bad++; $display("FAIL bounce_pix got=%h want=%h", vif.pixel_data, exp_pix); end
    end
    total++;
    if (nd !== nr || nr == 0) begin bad++; $display("FAIL bounce_count got=%0d want=%0d", nd, nr); end
  endtask

  task automatic test_pause();
    vif.shape_sel = 1'b0;
    vif.pause = 1'b1;
    for (int c = 0; c < 20; c++) begin
      probe(mx[c % NS] + ((c % 2) ? SZ : SZ - 1), my[c % NS]);
      total++;
      if (vif.pixel_data !== exp_pix) begin bad++; $display("FAIL pause_pix got=%h want=%h", vif.pixel_data, exp_pix); end
      total++;
      if (vif.bounce !== '0) begin bad++; $display("FAIL pause_bounce got=%b want=0", vif.bounce); end
    end
    vif.pause = 1'b0;
    for (int c = 0; c < 12; c++) begin
      probe(mx[0] + ((c % 2) ? SZ : SZ - 1), my[0]);
      total++;
      if (vif.pixel_data !== exp_pix) begin bad++; $display("FAIL unpause_pix got=%h want=%h", vif.pixel_data, exp_pix); end
      total++;
      if (vif.bounce !== exp_b) begin bad++; $display("FAIL unpause_bounce got=%b want=%b", vif.bounce, exp_b); end
    end
  endtask

  task automatic test_overlap_reset();
    bit found;
    found = 1'b0;
    vif.shape_sel = 1'b0;
    rst = 1'b1;
    probe(0, 0);
    rst = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (mx[1] < mx[0] + SZ && mx[0] < mx[1] + SZ && my[1] < my[0] + SZ && my[0] < my[1] + SZ) begin
        probe(mx[0] > mx[1] ? mx[0] : mx[1], my[0] > my[1] ? my[0] : my[1]);
        found = 1'b1;
        total++;
        if (vif.pixel_data !== C_RED) begin bad++; $display("FAIL overlap_pix got=%h want=%h", vif.pixel_data, C_RED); end
      end else begin
        probe(mx[0] + SZ - 1, my[0]);
        total++;
        if (vif.pixel_data !== exp_pix) begin bad++; $display("FAIL approach_pix got=%h want=%h", vif.pixel_data, exp_pix); end
      end
    end
    total++;
    if (!found) begin bad++; $display("FAIL overlap_timeout got=none want=overlap"); end
    repeat (7) probe(300, 300);
    vif.pause = 1'b1;
    rst = 1'b1;
    probe(48, 48);
    total++;
    if (vif.pixel_data !== C_BLACK) begin bad++; $display("FAIL midreset_pix got=%h want=%h", vif.pixel_data, C_BLACK); end
    total++;
    if (vif.bounce !== '0) begin bad++; $display("FAIL midreset_bounce got=%b want=0", vif.bounce); end
    rst = 1'b0;
    vif.pause = 1'b0;
    probe(48, 48);
    total++;
    if (vif.pixel_data !== C_RED) begin bad++; $display("FAIL home_spr0 got=%h want=%h", vif.pixel_data, C_RED); end
    probe(96, 64);
    total++;
    if (vif.pixel_data !== C_GREEN) begin bad++; $display("FAIL home_spr1 got=%h want=%h", vif.pixel_data, C_GREEN); end
    probe(192, 96);
    total++;
    if (vif.pixel_data !== C_MAGENTA) begin bad++; $display("FAIL home_spr3 got=%h want=%h", vif.pixel_data, C_MAGENTA); end
    probe(88, 48);
    total++;
    if (vif.pixel_data !== C_WHITE) begin bad++; $display("FAIL home_gap got=%h want=%h", vif.pixel_data, C_WHITE); end
  endtask

  initial begin
    vif.pause = 1'b0;
    vif.shape_sel = 1'b0;
    vif.pixel_xpos = '0;
    vif.pixel_ypos = '0;
    test_reset();
    test_square(300);
    test_circle(300);
    test_bounce(1800);
    test_pause();
    test_overlap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
